// File: rtl/router_out_drain.sv
// router_out_drain
//   Drains one router output port a packet at a time. When the port reports
//   data (vld_out), the block waits START_DLY cycles, then issues read_enb and
//   pulls the header {len, addr}, len payload bytes and one parity byte.
//   Payload bytes are presented on rx_data/rx_data_valid. Each packet ends in
//   a one-cycle pkt_done carrying parity/address/truncation status.
//
// Ports
//   clock, resetn        : clock, asynchronous active-low reset
//   vld_out, data_out    : router port status and data (data one cycle after read)
//   read_enb             : combinational read request to the router
//   rx_data, rx_data_valid : registered payload byte and its strobe
//   pkt_done             : one-cycle end-of-packet strobe
//   pkt_len              : len field of the most recent header
//   parity_err, addr_err, trunc_err : status, valid only with pkt_done
//   pkt_count            : number of pkt_done strobes (wraps)
module router_out_drain #(
    parameter int unsigned START_DLY = 2,
    parameter logic [1:0]  PORT_ADDR = 2'b01,
    parameter int unsigned STALL_MAX = 32
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic       trunc_err,
    output logic [7:0] pkt_count
);

    localparam int DLY_W   = 5;
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, READ, DONE} state_t;

    state_t               state, state_nxt;
    logic [DLY_W-1:0]     dly_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic [6:0]           issued;
    logic [6:0]           rcv_idx;
    logic                 hdr_seen;
    logic                 rd_vld_p1;
    logic [7:0]           xor_acc;
    logic                 par_err_r, addr_err_r, trunc_r;

    logic [6:0]           target;
    logic                 reads_left;
    logic                 stalled, stall_hit;
    logic                 byte_hdr, byte_pay, byte_par;

    // Until the header lands only header + parity are known to exist, so a
    // len=0 packet never over-reads.
    assign target     = hdr_seen ? (7'(pkt_len) + 7'd2) : 7'd2;
    assign reads_left = (issued < target);
    assign read_enb   = (state == READ) && vld_out && reads_left;
    assign stalled    = (state == READ) && !vld_out && reads_left;
    assign stall_hit  = stalled && (stall_cnt == STALL_W'(STALL_MAX - 1));

    // ---- stage p1: byte returned by the router for the read accepted last cycle
    assign byte_hdr = (state == READ) && rd_vld_p1 && !hdr_seen;
    assign byte_par = (state == READ) && rd_vld_p1 && hdr_seen &&
                      (rcv_idx == 7'(pkt_len) + 7'd1);
    assign byte_pay = (state == READ) && rd_vld_p1 && hdr_seen && !byte_par;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (vld_out) state_nxt = (START_DLY == 0) ? READ : WAIT;
            WAIT: begin
                // vld_out falling here means the router soft-reset its port
                if (!vld_out)
                    state_nxt = IDLE;
                else if (dly_cnt == DLY_W'(START_DLY - 1))
                    state_nxt = READ;
            end
            READ: if (byte_par || stall_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dly_cnt <= '0;
        end else if (state == WAIT) begin
            dly_cnt <= dly_cnt + DLY_W'(1);
        end else begin
            dly_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            issued    <= '0;
            rcv_idx   <= '0;
            hdr_seen  <= 1'b0;
            stall_cnt <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= read_enb;
            if (state != READ) begin
                issued    <= '0;
                rcv_idx   <= '0;
                hdr_seen  <= 1'b0;
                stall_cnt <= '0;
            end else begin
                if (read_enb) begin
                    issued    <= issued + 7'd1;
                    stall_cnt <= '0;
                end else if (stalled) begin
                    stall_cnt <= stall_cnt + STALL_W'(1);
                end
                if (rd_vld_p1)
                    rcv_idx <= rcv_idx + 7'd1;
                if (byte_hdr)
                    hdr_seen <= 1'b1;
            end
        end
    end

    // ---- stage p2: registered payload output, header capture and parity
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            pkt_len       <= 6'd0;
            xor_acc       <= 8'h00;
        end else begin
            rx_data_valid <= byte_pay;
            if (byte_pay)
                rx_data <= data_out;
            if (byte_hdr) begin
                pkt_len <= data_out[7:2];
                xor_acc <= data_out;
            end else if (byte_pay) begin
                xor_acc <= xor_acc ^ data_out;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            par_err_r  <= 1'b0;
            addr_err_r <= 1'b0;
            trunc_r    <= 1'b0;
        end else if (state == IDLE) begin
            par_err_r  <= 1'b0;
            addr_err_r <= 1'b0;
            trunc_r    <= 1'b0;
        end else begin
            if (byte_hdr)
                addr_err_r <= (data_out[1:0] != PORT_ADDR);
            if (byte_par)
                par_err_r <= (data_out != xor_acc);
            if (stall_hit)
                trunc_r <= 1'b1;
        end
    end

    // Counted on entry to DONE so the new value is visible with pkt_done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            pkt_count <= 8'd0;
        else if (state == READ && state_nxt == DONE)
            pkt_count <= pkt_count + 8'd1;
    end

    assign pkt_done   = (state == DONE);
    assign parity_err = pkt_done & par_err_r;
    assign addr_err   = pkt_done & addr_err_r;
    assign trunc_err  = pkt_done & trunc_r;

endmodule

// File: tb/tb_router_out_drain.sv
module tb_router_out_drain;

    logic       clock;
    logic       resetn;
    logic       vld_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       pkt_done;
    logic [5:0] pkt_len;
    logic       parity_err;
    logic       addr_err;
    logic       trunc_err;
    logic [7:0] pkt_count;

    router_out_drain #(
        .START_DLY(2),
        .PORT_ADDR(2'b01),
        .STALL_MAX(32)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .vld_out(vld_out),
        .data_out(data_out),
        .read_enb(read_enb),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .pkt_done(pkt_done),
        .pkt_len(pkt_len),
        .parity_err(parity_err),
        .addr_err(addr_err),
        .trunc_err(trunc_err),
        .pkt_count(pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] len;
        logic       par;
        logic       addr;
        logic       trunc;
        logic [7:0] cnt;
    } exp_pkt_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rx[$];
    exp_pkt_t   exp_pkt[$];
    logic [7:0] fifo[$];
    logic [7:0] pay_tbl[0:15];
    int         exp_count = 0;
    int         rx_seen   = 0;
    int         done_seen = 0;
    int         rd_cnt    = 0;
    int         gap_reads = 0;
    int         popped    = 0;
    int         hold_at   = -1;
    int         hold_left = 0;
    bit         pulse     = 1'b0;
    bit         rd_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Router port model: a read accepted at a rising edge puts the next byte on
    // data_out for the following cycle; vld_out reflects a non-empty queue.
    initial begin
        vld_out    = 1'b0;
        data_out   = 8'h00;
        rd_pending = 1'b0;
        forever begin
            bit in_gap;
            @(negedge clock);
            if (!resetn) rd_pending = 1'b0;
            if (rd_pending && fifo.size() > 0) begin
                data_out = fifo.pop_front();
                popped++;
            end
            in_gap = (hold_left > 0) && (popped == hold_at);
            if (in_gap) hold_left--;
            vld_out = pulse || (fifo.size() > 0 && !in_gap);
            #1;
            rd_pending = read_enb;
            if (read_enb) begin
                rd_cnt++;
                if (in_gap) gap_reads++;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (rx_data_valid) begin
                    if (exp_rx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no strobe", rx_data);
                    end else begin
                        check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                    end
                    rx_seen++;
                end
                if (pkt_done) begin
                    if (exp_pkt.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pkt_unexpected: got pkt_done len %0d, expected none", pkt_len);
                    end else begin
                        exp_pkt_t e;
                        e = exp_pkt.pop_front();
                        check("pkt_len",    32'(pkt_len),    32'(e.len));
                        check("parity_err", 32'(parity_err), 32'(e.par));
                        check("addr_err",   32'(addr_err),   32'(e.addr));
                        check("trunc_err",  32'(trunc_err),  32'(e.trunc));
                        check("pkt_count",  32'(pkt_count),  32'(e.cnt));
                    end
                    done_seen++;
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Queue one packet in the router model and the expected results in the
    // scoreboard, then wait (bounded) for its pkt_done and check read count.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] seed,
                            input logic [7:0] par_flip, input int h_at,
                            input int h_len, input bit trunc);
        logic [7:0] x, b;
        int         len, rd0, done0, i;
        exp_pkt_t   e;
        len       = int'(hdr[7:2]);
        popped    = 0;
        hold_at   = h_at;
        hold_left = h_len;
        gap_reads = 0;
        rd0       = rd_cnt;
        done0     = done_seen;
        x         = hdr;
        fifo.push_back(hdr);
        for (int j = 0; j < len; j++) begin
            b = pay_tbl[j % 16] ^ seed;
            fifo.push_back(b);
            x = x ^ b;
            if (!trunc || j < h_at - 1) exp_rx.push_back(b);
        end
        fifo.push_back(x ^ par_flip);
        exp_count = (exp_count + 1) % 256;
        e.len   = hdr[7:2];
        e.par   = (par_flip != 8'h00) && !trunc;
        e.addr  = (hdr[1:0] != 2'b01);
        e.trunc = trunc;
        e.cnt   = 8'(exp_count);
        exp_pkt.push_back(e);
        i = 0;
        while (done_seen == done0 && i < 400) begin
            @(negedge clock);
            #2;
            i++;
        end
        check("pkt_done_seen", 32'(done_seen - done0), 32'd1);
        if (trunc) begin
            fifo.delete();
            hold_left = 0;
        end
        check("read_count", 32'(rd_cnt - rd0), trunc ? 32'(h_at) : 32'(len + 2));
        idle(4);
    endtask

    initial begin
        int rd0, done0, i;
        pay_tbl = '{8'h3C, 8'hA5, 8'h07, 8'hF0, 8'h5A, 8'h99, 8'h12, 8'hE4,
                    8'h6B, 8'h80, 8'h01, 8'hCD, 8'h77, 8'h2E, 8'hB3, 8'h48};
        resetn = 1'b1;
        #3 resetn = 1'b0;
        #1;
        check("reset_outputs",
              32'({read_enb, rx_data, rx_data_valid, pkt_done, pkt_len,
                   parity_err, addr_err, trunc_err, pkt_count}), 32'd0);
        idle(3);
        resetn = 1'b1;
        idle(2);

        // len=14 addr 01, good parity
        send_pkt(8'h39, 8'h00, 8'h00, -1, 0, 1'b0);
        // len=0: header + parity only
        send_pkt(8'h01, 8'h00, 8'h00, -1, 0, 1'b0);
        // len=5, corrupted parity
        send_pkt(8'h15, 8'h21, 8'h80, -1, 0, 1'b0);
        // len=3, wrong address 2'b10
        send_pkt(8'h0E, 8'h44, 8'h00, -1, 0, 1'b0);
        // 3-cycle vld_out gap after payload byte 4
        send_pkt(8'h39, 8'h13, 8'h00, 5, 3, 1'b0);
        check("gap_reads", 32'(gap_reads), 32'd0);
        // gap long enough to abort the packet
        send_pkt(8'h39, 8'h6C, 8'h00, 5, 40, 1'b1);

        // single-cycle vld_out pulse in IDLE must not start a read
        rd0   = rd_cnt;
        done0 = done_seen;
        @(negedge clock);
        pulse = 1'b1;
        @(negedge clock);
        pulse = 1'b0;
        idle(10);
        check("pulse_reads", 32'(rd_cnt - rd0), 32'd0);
        check("pulse_done",  32'(done_seen - done0), 32'd0);

        // reset after payload byte 7 of a 14-byte packet
        popped    = 0;
        hold_at   = -1;
        hold_left = 0;
        rd0       = rx_seen;
        fifo.push_back(8'h39);
        for (int j = 0; j < 14; j++) begin
            fifo.push_back(pay_tbl[j] ^ 8'h5A);
            if (j < 7) exp_rx.push_back(pay_tbl[j] ^ 8'h5A);
        end
        fifo.push_back(8'h00);
        i = 0;
        while (rx_seen < rd0 + 7 && i < 200) begin
            @(negedge clock);
            #2;
            i++;
        end
        check("rx_before_reset", 32'(rx_seen - rd0), 32'd7);
        resetn = 1'b0;
        #1;
        check("midpkt_reset_outputs",
              32'({read_enb, rx_data, rx_data_valid, pkt_done, pkt_len,
                   parity_err, addr_err, trunc_err, pkt_count}), 32'd0);
        fifo.delete();
        exp_count = 0;
        idle(3);
        resetn = 1'b1;
        idle(10);
        check("count_after_reset", 32'(pkt_count), 32'd0);

        check("exp_rx_left",  32'(exp_rx.size()),  32'd0);
        check("exp_pkt_left", 32'(exp_pkt.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "simulation timeout");
    end

endmodule
